// File: rtl/hazard_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_controller_if
// Bundles the pipeline-side signals of the hazard controller.
//   ID_*         : register fields of the instruction in ID and their use bits
//   EX/MEM/WB_*  : destination register and write enable of each later stage
//   EX_load_instr: the instruction in EX is a load
//   branch_taken : a taken branch/BL was resolved in ID this cycle
//   LE_PC, LE_IFID, S, IFID_flush : pipeline control outputs
//   fwd_A/B/C    : operand source for Rn/Rm/Rd (00 RF, 01 EX, 10 MEM, 11 WB)
//   stall_cnt, flush_cnt : saturating event counters
//   state        : FSM state (00 BOOT, 01 RUN, 10 FLUSH)
// The master modport belongs to the pipeline side; the slave modport belongs
// to the controller.
// -----------------------------------------------------------------------------
interface hazard_controller_if;
  logic [3:0]  ID_rn, ID_rm, ID_rd;
  logic        ID_use_rn, ID_use_rm, ID_use_rd;
  logic [3:0]  EX_rd, MEM_rd, WB_rd;
  logic        EX_RF_enable, MEM_RF_enable, WB_RF_enable;
  logic        EX_load_instr;
  logic        branch_taken;

  logic        LE_PC;
  logic        LE_IFID;
  logic        S;
  logic        IFID_flush;
  logic [1:0]  fwd_A, fwd_B, fwd_C;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state;

  modport master (
    output ID_rn, ID_rm, ID_rd, ID_use_rn, ID_use_rm, ID_use_rd,
           EX_rd, MEM_rd, WB_rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
           EX_load_instr, branch_taken,
    input  LE_PC, LE_IFID, S, IFID_flush, fwd_A, fwd_B, fwd_C,
           stall_cnt, flush_cnt, state
  );

  modport slave (
    input  ID_rn, ID_rm, ID_rd, ID_use_rn, ID_use_rm, ID_use_rd,
           EX_rd, MEM_rd, WB_rd, EX_RF_enable, MEM_RF_enable, WB_RF_enable,
           EX_load_instr, branch_taken,
    output LE_PC, LE_IFID, S, IFID_flush, fwd_A, fwd_B, fwd_C,
           stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Pipeline hazard unit: load-use stall detection, taken-branch flush sequencing
// and operand forwarding selection.
//   clk : pipeline clock, rising edge
//   R   : asynchronous active-low reset
//   hz  : pipeline-side signals (see hazard_controller_if)
// FSM: BOOT (two cycles after reset) -> RUN <-> FLUSH (one cycle per taken
// branch). Stall/flush control is Mealy in RUN; forwarding is purely
// combinational in every state.
// -----------------------------------------------------------------------------
module hazard_controller (
  input  logic                 clk,
  input  logic                 R,
  hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  localparam logic [3:0]  REG_PC  = 4'd15;

  state_e      state_q, state_d;
  logic        boot_cnt_q, boot_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;

  // Operand source for one register field. EX is skipped when it holds a load
  // because the loaded value does not exist yet (that case stalls instead).
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] field,
    input logic       use_field,
    input logic [3:0] ex_rd,
    input logic       ex_ok,
    input logic [3:0] mem_rd,
    input logic       mem_ok,
    input logic [3:0] wb_rd,
    input logic       wb_ok
  );
    if (!use_field || field == REG_PC)  return 2'b00;
    else if (ex_ok  && ex_rd  == field) return 2'b01;
    else if (mem_ok && mem_rd == field) return 2'b10;
    else if (wb_ok  && wb_rd  == field) return 2'b11;
    else                                return 2'b00;
  endfunction

  always_comb begin
    load_use = hz.EX_load_instr && hz.EX_RF_enable &&
               ((hz.ID_use_rn && hz.EX_rd == hz.ID_rn) ||
                (hz.ID_use_rm && hz.EX_rd == hz.ID_rm) ||
                (hz.ID_use_rd && hz.EX_rd == hz.ID_rd));
  end

  always_comb begin
    hz.fwd_A = fwd_sel(hz.ID_rn, hz.ID_use_rn,
                       hz.EX_rd,  hz.EX_RF_enable && !hz.EX_load_instr,
                       hz.MEM_rd, hz.MEM_RF_enable,
                       hz.WB_rd,  hz.WB_RF_enable);
    hz.fwd_B = fwd_sel(hz.ID_rm, hz.ID_use_rm,
                       hz.EX_rd,  hz.EX_RF_enable && !hz.EX_load_instr,
                       hz.MEM_rd, hz.MEM_RF_enable,
                       hz.WB_rd,  hz.WB_RF_enable);
    hz.fwd_C = fwd_sel(hz.ID_rd, hz.ID_use_rd,
                       hz.EX_rd,  hz.EX_RF_enable && !hz.EX_load_instr,
                       hz.MEM_rd, hz.MEM_RF_enable,
                       hz.WB_rd,  hz.WB_RF_enable);
  end

  // Next state and Mealy outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    hz.LE_PC      = 1'b1;
    hz.LE_IFID    = 1'b1;
    hz.S          = 1'b1;
    hz.IFID_flush = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q) begin
          boot_cnt_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          boot_cnt_d = 1'b1;
        end
      end

      ST_RUN: begin
        hz.S = 1'b0;
        // A stall outranks a taken branch: the branch is re-presented once the
        // stall clears, so dropping it here loses nothing.
        if (load_use) begin
          hz.LE_PC   = 1'b0;
          hz.LE_IFID = 1'b0;
          hz.S       = 1'b1;
          if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (hz.branch_taken) begin
          hz.IFID_flush = 1'b1;
          state_d       = ST_FLUSH;
          if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 16'd1;
        end
      end

      ST_FLUSH: begin
        // Bubble the wrong-path instruction sitting in ID; inputs are ignored.
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of the others, independent of statement order.
    if (!R) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
  assign hz.state     = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
// Self-checking bench for hazard_controller: hand-written sequences for boot,
// stall, flush, priority, saturation and reset abort; a table of forwarding
// vectors; and randomized stimulus compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

  logic clk;
  logic R;
  hazard_controller_if hif ();

  hazard_controller dut (
    .clk (clk),
    .R   (R),
    .hz  (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 BOOT, 1 RUN, 2 FLUSH; counters kept as plain ints.
  int m_state;
  int m_boot_cycles;
  int m_stall;
  int m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state       = 0;
    m_boot_cycles = 0;
    m_stall       = 0;
    m_flush       = 0;
  endtask

  // Load-use: EX holds a writing load whose rd is read by the ID instruction.
  function automatic bit m_load_use();
    logic [3:0] f[3];
    bit         u[3];
    f = '{hif.ID_rn, hif.ID_rm, hif.ID_rd};
    u = '{hif.ID_use_rn, hif.ID_use_rm, hif.ID_use_rd};
    if (!(hif.EX_load_instr && hif.EX_RF_enable)) return 0;
    foreach (f[i]) if (u[i] && f[i] == hif.EX_rd) return 1;
    return 0;
  endfunction

  // First younger stage holding the field wins; index + 1 is the encoding.
  function automatic logic [1:0] m_fwd(input logic [3:0] field, input bit use_f);
    logic [3:0] rd[3];
    bit         ok[3];
    rd = '{hif.EX_rd, hif.MEM_rd, hif.WB_rd};
    ok = '{hif.EX_RF_enable && !hif.EX_load_instr, hif.MEM_RF_enable, hif.WB_RF_enable};
    if (!use_f || field == 4'd15) return 2'b00;
    for (int i = 0; i < 3; i++) if (ok[i] && rd[i] == field) return 2'(i + 1);
    return 2'b00;
  endfunction

  task automatic model_edge();
    if (!R) begin
      model_reset();
    end else begin
      case (m_state)
        0: begin
          m_boot_cycles++;
          if (m_boot_cycles == 2) begin
            m_state = 1;
            m_boot_cycles = 0;
          end
        end
        1: begin
          if (m_load_use()) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
          else if (hif.branch_taken) begin
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            m_state = 2;
          end
        end
        default: m_state = 1;
      endcase
    end
  endtask

  // Compare every output against the model; call at posedge+1.
  task automatic cmp_model(input string tag);
    logic exp_le, exp_s, exp_fl;
    #2;
    exp_le = 1'b1; exp_s = 1'b1; exp_fl = 1'b0;
    if (R && m_state == 1) begin
      if (m_load_use())          begin exp_le = 1'b0; exp_s = 1'b1; end
      else if (hif.branch_taken) begin exp_s = 1'b0; exp_fl = 1'b1; end
      else                       begin exp_s = 1'b0; end
    end
    check({tag, ".state"},      32'(hif.state),      32'(m_state));
    check({tag, ".LE_PC"},      32'(hif.LE_PC),      32'(exp_le));
    check({tag, ".LE_IFID"},    32'(hif.LE_IFID),    32'(exp_le));
    check({tag, ".S"},          32'(hif.S),          32'(exp_s));
    check({tag, ".IFID_flush"}, 32'(hif.IFID_flush), 32'(exp_fl));
    check({tag, ".fwd_A"},      32'(hif.fwd_A),      32'(m_fwd(hif.ID_rn, hif.ID_use_rn)));
    check({tag, ".fwd_B"},      32'(hif.fwd_B),      32'(m_fwd(hif.ID_rm, hif.ID_use_rm)));
    check({tag, ".fwd_C"},      32'(hif.fwd_C),      32'(m_fwd(hif.ID_rd, hif.ID_use_rd)));
    check({tag, ".stall_cnt"},  32'(hif.stall_cnt),  32'(m_stall));
    check({tag, ".flush_cnt"},  32'(hif.flush_cnt),  32'(m_flush));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    hif.ID_rn = '0; hif.ID_rm = '0; hif.ID_rd = '0;
    hif.ID_use_rn = 1'b0; hif.ID_use_rm = 1'b0; hif.ID_use_rd = 1'b0;
    hif.EX_rd = '0; hif.MEM_rd = '0; hif.WB_rd = '0;
    hif.EX_RF_enable = 1'b0; hif.MEM_RF_enable = 1'b0; hif.WB_RF_enable = 1'b0;
    hif.EX_load_instr = 1'b0; hif.branch_taken = 1'b0;
  endtask

  task automatic drive_load_use();
    hif.EX_load_instr = 1'b1; hif.EX_RF_enable = 1'b1; hif.EX_rd = 4'd3;
    hif.ID_rn = 4'd3; hif.ID_use_rn = 1'b1;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  typedef struct {
    logic [3:0] rn, rm, rd;
    logic       urn, urm, urd;
    logic [3:0] ex_rd, mem_rd, wb_rd;
    logic       ex_en, mem_en, wb_en, ex_ld;
    logic [1:0] ea, eb, ec;
  } vec_t;

  vec_t vecs[8];

  initial begin
    R = 1'b0;
    clear_inputs();
    model_reset();

    vecs[0] = '{4'd1, 4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00};
    vecs[1] = '{4'd1, 4'd5, 4'd2, 1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00};
    vecs[2] = '{4'd1, 4'd15, 4'd2, 1'b0, 1'b1, 1'b0, 4'd15, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[3] = '{4'd4, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1, 4'd4, 4'd4, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10};
    vecs[4] = '{4'd7, 4'd6, 4'd3, 1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00};
    vecs[5] = '{4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00};
    vecs[6] = '{4'd9, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01};
    vecs[7] = '{4'd15, 4'd8, 4'd8, 1'b1, 1'b1, 1'b0, 4'd15, 4'd8, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00};

    // Reset and boot
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", 32'(hif.state), 32'd0);
    check("rst.S", 32'(hif.S), 32'd1);
    check("rst.LE_PC", 32'(hif.LE_PC), 32'd1);
    check("rst.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    R = 1'b1;
    cmp_model("boot1"); check("boot1.state", 32'(hif.state), 32'd0); check("boot1.S", 32'(hif.S), 32'd1); tick();
    cmp_model("boot2"); check("boot2.state", 32'(hif.state), 32'd0); check("boot2.S", 32'(hif.S), 32'd1); tick();
    cmp_model("run0");
    check("run0.state", 32'(hif.state), 32'd1);
    check("run0.S", 32'(hif.S), 32'd0);
    check("run0.LE_PC", 32'(hif.LE_PC), 32'd1);
    tick();

    // Single load-use stall
    drive_load_use();
    cmp_model("stall");
    check("stall.LE_PC", 32'(hif.LE_PC), 32'd0);
    check("stall.LE_IFID", 32'(hif.LE_IFID), 32'd0);
    check("stall.S", 32'(hif.S), 32'd1);
    tick();
    clear_inputs();
    cmp_model("post_stall");
    check("post_stall.S", 32'(hif.S), 32'd0);
    check("post_stall.stall_cnt", 32'(hif.stall_cnt), 32'd1);
    tick();

    // Taken branch, with branch and hazard presented again during FLUSH
    hif.branch_taken = 1'b1;
    cmp_model("br");
    check("br.IFID_flush", 32'(hif.IFID_flush), 32'd1);
    check("br.S", 32'(hif.S), 32'd0);
    tick();
    drive_load_use();
    cmp_model("flush");
    check("flush.state", 32'(hif.state), 32'd2);
    check("flush.S", 32'(hif.S), 32'd1);
    check("flush.LE_PC", 32'(hif.LE_PC), 32'd1);
    check("flush.IFID_flush", 32'(hif.IFID_flush), 32'd0);
    tick();
    clear_inputs();
    cmp_model("post_flush");
    check("post_flush.state", 32'(hif.state), 32'd1);
    check("post_flush.flush_cnt", 32'(hif.flush_cnt), 32'd1);
    check("post_flush.stall_cnt", 32'(hif.stall_cnt), 32'd1);
    tick();

    // Stall beats branch in the same cycle
    drive_load_use();
    hif.branch_taken = 1'b1;
    cmp_model("both");
    check("both.IFID_flush", 32'(hif.IFID_flush), 32'd0);
    check("both.LE_PC", 32'(hif.LE_PC), 32'd0);
    tick();
    clear_inputs();
    cmp_model("post_both");
    check("post_both.state", 32'(hif.state), 32'd1);
    check("post_both.flush_cnt", 32'(hif.flush_cnt), 32'd1);
    check("post_both.stall_cnt", 32'(hif.stall_cnt), 32'd2);
    tick();

    // Forwarding vectors
    for (int i = 0; i < 8; i++) begin
      hif.ID_rn = vecs[i].rn; hif.ID_rm = vecs[i].rm; hif.ID_rd = vecs[i].rd;
      hif.ID_use_rn = vecs[i].urn; hif.ID_use_rm = vecs[i].urm; hif.ID_use_rd = vecs[i].urd;
      hif.EX_rd = vecs[i].ex_rd; hif.MEM_rd = vecs[i].mem_rd; hif.WB_rd = vecs[i].wb_rd;
      hif.EX_RF_enable = vecs[i].ex_en; hif.MEM_RF_enable = vecs[i].mem_en;
      hif.WB_RF_enable = vecs[i].wb_en; hif.EX_load_instr = vecs[i].ex_ld;
      #2;
      check($sformatf("vec%0d.fwd_A", i), 32'(hif.fwd_A), 32'(vecs[i].ea));
      check($sformatf("vec%0d.fwd_B", i), 32'(hif.fwd_B), 32'(vecs[i].eb));
      check($sformatf("vec%0d.fwd_C", i), 32'(hif.fwd_C), 32'(vecs[i].ec));
      @(posedge clk);
      model_edge();
      #1;
    end
    clear_inputs();

    // Randomized stimulus against the model
    for (int n = 0; n < 400; n++) begin
      hif.ID_rn = rnd_reg(); hif.ID_rm = rnd_reg(); hif.ID_rd = rnd_reg();
      hif.ID_use_rn = 1'($urandom_range(0, 1));
      hif.ID_use_rm = 1'($urandom_range(0, 1));
      hif.ID_use_rd = 1'($urandom_range(0, 1));
      hif.EX_rd = rnd_reg(); hif.MEM_rd = rnd_reg(); hif.WB_rd = rnd_reg();
      hif.EX_RF_enable  = 1'($urandom_range(0, 1));
      hif.MEM_RF_enable = 1'($urandom_range(0, 1));
      hif.WB_RF_enable  = 1'($urandom_range(0, 1));
      hif.EX_load_instr = ($urandom_range(0, 9) < 3);
      hif.branch_taken  = ($urandom_range(0, 3) == 0);
      cmp_model($sformatf("rnd%0d", n));
      tick();
    end
    clear_inputs();

    // Saturation of stall_cnt
    drive_load_use();
    repeat (70000) tick();
    cmp_model("sat");
    check("sat.stall_cnt", 32'(hif.stall_cnt), 32'hFFFF);
    tick();
    cmp_model("sat_hold");
    check("sat_hold.stall_cnt", 32'(hif.stall_cnt), 32'hFFFF);
    tick();

    // Reset in the middle of a FLUSH cycle
    clear_inputs();
    hif.branch_taken = 1'b1;
    cmp_model("pre_abort_flush");
    tick();
    hif.branch_taken = 1'b0;
    check("abort_flush.in_flush", 32'(hif.state), 32'd2);
    R = 1'b0;
    model_reset();
    #1;
    check("abort_flush.state", 32'(hif.state), 32'd0);
    check("abort_flush.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    check("abort_flush.flush_cnt", 32'(hif.flush_cnt), 32'd0);
    check("abort_flush.S", 32'(hif.S), 32'd1);
    tick();
    R = 1'b1;
    cmp_model("reboot1"); tick();
    cmp_model("reboot2"); tick();
    cmp_model("reboot_run"); tick();

    // Reset in the middle of a stall cycle, hazard held through boot
    drive_load_use();
    #2;
    check("pre_abort_stall.LE_PC", 32'(hif.LE_PC), 32'd0);
    R = 1'b0;
    model_reset();
    #1;
    check("abort_stall.state", 32'(hif.state), 32'd0);
    check("abort_stall.LE_PC", 32'(hif.LE_PC), 32'd1);
    check("abort_stall.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    R = 1'b1;
    cmp_model("abort_boot1"); tick();
    cmp_model("abort_boot2"); tick();
    check("abort_boot_end.stall_cnt", 32'(hif.stall_cnt), 32'd0);
    cmp_model("abort_run"); tick();
    cmp_model("abort_run2");
    check("abort_run2.stall_cnt", 32'(hif.stall_cnt), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
